// File: rtl/rps_rr_arb.sv
// rps_rr_arb: N-way rotating-priority arbiter with grant lock.
// Same-cycle grant from registered pointer and lock state.
module rps_rr_arb #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          en,
  input  logic [N-1:0]  req,
  input  logic          hold,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx,
  output logic [IW-1:0] ptr,
  output logic          locked
);

  logic [IW-1:0] lock_idx;
  logic [IW-1:0] sel_idx;
  logic          sel_hit;
  logic [IW-1:0] cand;
  logic          lock_hit;
  logic [IW-1:0] win_idx;
  logic          win;

  // Rotating search: first requester at or after ptr, wrapping.
  always_comb begin
    sel_idx = '0;
    sel_hit = 1'b0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = ptr + IW'(k);
      if (req[cand]) begin
        sel_hit = 1'b1;
        sel_idx = cand;
      end
    end
  end

  // Lock wins while its owner still requests; otherwise fall through.
  always_comb begin
    lock_hit  = locked & req[lock_idx];
    win_idx   = lock_hit ? lock_idx : sel_idx;
    win       = (lock_hit | sel_hit) & en & reset_n;
    gnt_valid = win;
    gnt_idx   = win ? win_idx : '0;
    gnt       = win ? (N'(1) << win_idx) : '0;
  end

  // Pointer and lock update; frozen while disabled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr      <= '0;
      locked   <= 1'b0;
      lock_idx <= '0;
    end else if (en) begin
      if (gnt_valid && hold) begin
        locked   <= 1'b1;
        lock_idx <= gnt_idx;
      end else if (gnt_valid) begin
        locked <= 1'b0;
        ptr    <= gnt_idx + IW'(1);
      end else begin
        locked <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rps_rr_arb.sv
// tb_rps_rr_arb: directed and soak checks for rps_rr_arb.
// Covers N=8 and N=2 instances.
module tb_rps_rr_arb;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       en;
  logic [7:0] req;
  logic       hold;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [2:0] ptr;
  logic       locked;

  logic [1:0] req2;
  logic       hold2 = 1'b0;
  logic [1:0] gnt2;
  logic       gnt_valid2;
  logic       gnt_idx2;
  logic       ptr2;
  logic       locked2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  rps_rr_arb #(.N(8)) dut (
    .clock(clock), .reset_n(reset_n), .en(en),
    .req(req), .hold(hold), .gnt(gnt),
    .gnt_valid(gnt_valid), .gnt_idx(gnt_idx),
    .ptr(ptr), .locked(locked)
  );

  rps_rr_arb #(.N(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .en(en),
    .req(req2), .hold(hold2), .gnt(gnt2),
    .gnt_valid(gnt_valid2), .gnt_idx(gnt_idx2),
    .ptr(ptr2), .locked(locked2)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    reset_n = 1'b0;
    en = 1'b1;
    hold = 1'b0;
    req = 8'hFF;
    req2 = 2'b00;
    #2;
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0) begin
      errors++;
      $display("FAIL rst_gnt: got %h/%b/%0d expected 00/0/0",
               gnt, gnt_valid, gnt_idx);
    end
    checks++;
    if (ptr !== 3'd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL rst_state: got ptr=%0d locked=%b expected 0/0",
               ptr, locked);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (gnt !== 8'h01) begin
      errors++;
      $display("FAIL rel_gnt: got %h expected 01", gnt);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = 8'h01 << (i % 8);
      checks++;
      if (gnt !== exp || ptr !== 3'(i % 8)) begin
        errors++;
        $display("FAIL walk%0d: got gnt=%h ptr=%0d expected %h/%0d",
                 i, gnt, ptr, exp, i % 8);
      end
    end
  endtask

  task automatic test_rotation();
    pulse_reset();
    req = 8'h04;
    tick();
    checks++;
    if (ptr !== 3'd3) begin
      errors++;
      $display("FAIL rot_setup: got ptr=%0d expected 3", ptr);
    end
    req = 8'b0010_0001;
    #1;
    checks++;
    if (gnt !== 8'h20 || gnt_idx !== 3'd5) begin
      errors++;
      $display("FAIL rot_skip: got %h/%0d expected 20/5", gnt, gnt_idx);
    end
    tick();
    checks++;
    if (ptr !== 3'd6 || gnt !== 8'h01) begin
      errors++;
      $display("FAIL rot_wrap: got ptr=%0d gnt=%h expected 6/01",
               ptr, gnt);
    end
    tick();
    checks++;
    if (ptr !== 3'd1) begin
      errors++;
      $display("FAIL rot_ptr: got %0d expected 1", ptr);
    end
  endtask

  task automatic test_lock();
    req = 8'h00;
    pulse_reset();
    req = 8'h06;
    hold = 1'b1;
    #1;
    checks++;
    if (gnt !== 8'h02) begin
      errors++;
      $display("FAIL lock_gnt: got %h expected 02", gnt);
    end
    tick();
    hold = 1'b0;
    #1;
    checks++;
    if (locked !== 1'b1 || ptr !== 3'd0 || gnt !== 8'h02) begin
      errors++;
      $display("FAIL lock_keep: got l=%b p=%0d g=%h expected 1/0/02",
               locked, ptr, gnt);
    end
    tick();
    checks++;
    if (locked !== 1'b0 || ptr !== 3'd2 || gnt !== 8'h04) begin
      errors++;
      $display("FAIL lock_end: got l=%b p=%0d g=%h expected 0/2/04",
               locked, ptr, gnt);
    end
  endtask

  task automatic test_lock_drop();
    req = 8'h00;
    pulse_reset();
    req = 8'h01;
    tick();
    req = 8'h02;
    hold = 1'b1;
    tick();
    checks++;
    if (locked !== 1'b1 || ptr !== 3'd1) begin
      errors++;
      $display("FAIL drop_setup: got l=%b p=%0d expected 1/1",
               locked, ptr);
    end
    hold = 1'b0;
    req = 8'h80;
    #1;
    checks++;
    if (gnt !== 8'h80 || gnt_idx !== 3'd7) begin
      errors++;
      $display("FAIL drop_gnt: got %h/%0d expected 80/7", gnt, gnt_idx);
    end
    tick();
    checks++;
    if (locked !== 1'b0 || ptr !== 3'd0) begin
      errors++;
      $display("FAIL drop_state: got l=%b p=%0d expected 0/0",
               locked, ptr);
    end
  endtask

  task automatic test_enable();
    req = 8'h00;
    pulse_reset();
    req = 8'h10;
    hold = 1'b1;
    tick();
    en = 1'b0;
    #1;
    checks++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
      errors++;
      $display("FAIL en_off_gnt: got %h/%b expected 00/0", gnt, gnt_valid);
    end
    req = 8'h11;
    repeat (3) tick();
    checks++;
    if (ptr !== 3'd0 || locked !== 1'b1 || gnt !== 8'h00) begin
      errors++;
      $display("FAIL en_frozen: got p=%0d l=%b g=%h expected 0/1/00",
               ptr, locked, gnt);
    end
    en = 1'b1;
    #1;
    checks++;
    if (gnt !== 8'h10 || gnt_idx !== 3'd4) begin
      errors++;
      $display("FAIL en_resume: got %h/%0d expected 10/4", gnt, gnt_idx);
    end
    tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if (locked !== 1'b0 || ptr !== 3'd0 || gnt !== 8'h00) begin
      errors++;
      $display("FAIL async_rst: got l=%b p=%0d g=%h expected 0/0/00",
               locked, ptr, gnt);
    end
    reset_n = 1'b1;
    hold = 1'b0;
    #1;
    checks++;
    if (gnt !== 8'h01) begin
      errors++;
      $display("FAIL post_rst: got %h expected 01", gnt);
    end
  endtask

  task automatic test_fairness();
    int wt8 [8];
    int wt2 [2];
    logic [7:0] m;
    hold = 1'b0;
    en = 1'b1;
    req = 8'h00;
    req2 = 2'b00;
    pulse_reset();
    for (int i = 0; i < 8; i++) wt8[i] = 0;
    for (int i = 0; i < 2; i++) wt2[i] = 0;
    for (int c = 0; c < 400; c++) begin
      m = 8'($urandom & $urandom);
      req = req ^ m;
      req2 = req2 ^ 2'($urandom & $urandom);
      #1;
      checks++;
      if (!$onehot0(gnt) || gnt_valid !== (|gnt) ||
          (gnt_valid ? (gnt !== (8'h01 << gnt_idx)) : (gnt_idx !== 3'd0))) begin
        errors++;
        $display("FAIL sb8_c%0d: got g=%h v=%b i=%0d", c,
                 gnt, gnt_valid, gnt_idx);
      end
      checks++;
      if (gnt_valid !== (|req) || gnt_valid2 !== (|req2)) begin
        errors++;
        $display("FAIL idle_c%0d: got v=%b/%b expected %b/%b", c,
                 gnt_valid, gnt_valid2, |req, |req2);
      end
      checks++;
      if (!$onehot0(gnt2) || gnt_valid2 !== (|gnt2) ||
          (gnt_valid2 ? (gnt2 !== (2'b01 << gnt_idx2)) : (gnt_idx2 !== 1'b0))) begin
        errors++;
        $display("FAIL sb2_c%0d: got g=%b v=%b i=%0d", c,
                 gnt2, gnt_valid2, gnt_idx2);
      end
      for (int i = 0; i < 8; i++) begin
        if (!req[i] || gnt[i]) wt8[i] = 0;
        else if (gnt_valid) wt8[i]++;
      end
      for (int i = 0; i < 2; i++) begin
        if (!req2[i] || gnt2[i]) wt2[i] = 0;
        else if (gnt_valid2) wt2[i]++;
      end
      checks++;
      if (wt8.max()[0] > 7 || wt2.max()[0] > 1) begin
        errors++;
        $display("FAIL starve_c%0d: got waits %0d/%0d limit 7/1", c,
                 wt8.max()[0], wt2.max()[0]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_lock();
    test_lock_drop();
    test_enable();
    test_fairness();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
